// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the restoring-division sequencer: datapath command
// codes, FSM state encodings and the RUN step counter width.
package div_ctrl_pkg;

   // Datapath command codes, identical to the restore datapath's decode
   localparam logic [2:0] CMD_NOP        = 3'd0;
   localparam logic [2:0] CMD_INITIALIZE = 3'd1;
   localparam logic [2:0] CMD_LOAD_Q     = 3'd2;
   localparam logic [2:0] CMD_LOAD_M     = 3'd3;
   localparam logic [2:0] CMD_RUN        = 3'd4;
   localparam logic [2:0] CMD_STORE_A    = 3'd5;
   localparam logic [2:0] CMD_STORE_Q    = 3'd6;
   localparam logic [2:0] CMD_SUBTRACT   = 3'd7;

   // Width of the RUN step counter; covers RUN_STEPS up to 15
   localparam int unsigned STEP_W = 4;

   // Legacy state encodings, kept so existing waveform decoders still match
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_INIT = 4'd1;
   localparam logic [3:0] ST_LDQ  = 4'd2;
   localparam logic [3:0] ST_LDM  = 4'd3;
   localparam logic [3:0] ST_SUB  = 4'd4;
   localparam logic [3:0] ST_RUN  = 4'd5;
   localparam logic [3:0] ST_STA  = 4'd6;
   localparam logic [3:0] ST_STQ  = 4'd7;
   localparam logic [3:0] ST_DONE = 4'd8;

   typedef enum logic [3:0] {
      S_IDLE = ST_IDLE,
      S_INIT = ST_INIT,
      S_LDQ  = ST_LDQ,
      S_LDM  = ST_LDM,
      S_SUB  = ST_SUB,
      S_RUN  = ST_RUN,
      S_STA  = ST_STA,
      S_STQ  = ST_STQ,
      S_DONE = ST_DONE
   } state_e;

   // Command issued during the command sub-phase of each state
   function automatic logic [2:0] state_cmd(input state_e s);
      case (s)
         S_INIT:  return CMD_INITIALIZE;
         S_LDQ:   return CMD_LOAD_Q;
         S_LDM:   return CMD_LOAD_M;
         S_SUB:   return CMD_SUBTRACT;
         S_RUN:   return CMD_RUN;
         S_STA:   return CMD_STORE_A;
         S_STQ:   return CMD_STORE_Q;
         default: return CMD_NOP;
      endcase
   endfunction

endpackage

// File: rtl/div_step_counter.sv
// Loadable up-counter with clear and enable, flagging when the count equals
// a terminal value. Paces the RUN loop of the division sequencer.
module div_step_counter
   import div_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = STEP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   input  logic [WIDTH-1:0] terminal,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   // Clear has priority over load, load over increment
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == terminal);

endmodule

// File: rtl/div_sequencer.sv
// Sequencer for the 8-bit restoring-division datapath: takes a request,
// walks the datapath through INITIALIZE/LOAD/SUBTRACT/RUN/STORE with a NOP
// after every command, and returns quotient and remainder. Divide-by-zero
// is answered locally without touching the datapath.
module div_sequencer
   import div_ctrl_pkg::*;
#(
   parameter int unsigned RUN_STEPS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_valid,
   output logic       start_ready,
   input  logic [7:0] dividend,
   input  logic [7:0] divisor,
   output logic [2:0] dp_enable,
   output logic [7:0] dp_inbus,
   input  logic [7:0] dp_outbus,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] quotient,
   output logic [7:0] remainder,
   output logic       div_by_zero,
   output logic       busy
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(RUN_STEPS - 1);

   state_e     state_q, state_d;
   logic       phase_q, phase_d;
   logic [7:0] dividend_q, divisor_q;
   logic       accept, res_done;
   logic       cnt_clear, cnt_en, cnt_tc;

   assign accept   = start_valid && start_ready && (state_q == S_IDLE);
   assign res_done = res_valid && res_ready;

   div_step_counter #(
      .WIDTH (STEP_W)
   ) u_step_counter (
      .clk        (clk),
      .rst        (rst),
      .clear      (cnt_clear),
      .load       (1'b0),
      .load_value ('0),
      .en         (cnt_en),
      .terminal   (LAST_STEP),
      .tc         (cnt_tc)
   );

   // Next-state logic: every command state spends one cycle issuing its
   // command (phase 0) and one cycle issuing NOP (phase 1)
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            phase_d = 1'b0;
            if (accept) begin
               state_d = (divisor == 8'd0) ? S_DONE : S_INIT;
            end
         end
         S_RUN: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               cnt_en  = 1'b1;
               if (cnt_tc) begin
                  state_d = S_STA;
               end
            end
         end
         S_DONE: begin
            phase_d = 1'b0;
            if (res_done) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               case (state_q)
                  S_INIT:  state_d = S_LDQ;
                  S_LDQ:   state_d = S_LDM;
                  S_LDM:   state_d = S_SUB;
                  S_SUB:   state_d = S_RUN;
                  S_STA:   state_d = S_STQ;
                  S_STQ:   state_d = S_DONE;
                  default: state_d = S_IDLE;
               endcase
               cnt_clear = (state_q == S_SUB);
            end
         end
      endcase
   end

   // State and phase registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
      end
   end

   // Operand capture on the request handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         dividend_q <= '0;
         divisor_q  <= '0;
      end else if (accept) begin
         dividend_q <= dividend;
         divisor_q  <= divisor;
      end
   end

   // Registered control outputs; handshake terms drop ready/valid on the
   // accepting edge so neither side sees a second transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         dp_enable   <= CMD_NOP;
         dp_inbus    <= '0;
         start_ready <= 1'b0;
         res_valid   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         dp_enable   <= phase_q ? CMD_NOP : state_cmd(state_q);
         dp_inbus    <= (state_q == S_LDQ) ? dividend_q :
                        (state_q == S_LDM) ? divisor_q  : '0;
         start_ready <= (state_q == S_IDLE) && !accept;
         res_valid   <= (state_q == S_DONE) && !res_done;
         busy        <= (state_d != S_IDLE);
      end
   end

   // Result capture: store phases sample the datapath while it drives A/Q
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept && (divisor == 8'd0)) begin
         quotient    <= 8'hFF;
         remainder   <= dividend;
         div_by_zero <= 1'b1;
      end else if (phase_q && (state_q == S_STA)) begin
         remainder <= dp_outbus;
      end else if (phase_q && (state_q == S_STQ)) begin
         quotient    <= dp_outbus;
         div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: two instances (RUN_STEPS=8 with an
// 8-bit restoring datapath model, RUN_STEPS=4 with a 4-bit one).
module tb_div_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic       sel = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;

   logic       start_ready_a, res_valid_a, div_by_zero_a, busy_a;
   logic [2:0] dp_enable_a;
   logic [7:0] dp_inbus_a, dp_outbus_a, quotient_a, remainder_a;
   logic       start_ready_b, res_valid_b, div_by_zero_b, busy_b;
   logic [2:0] dp_enable_b;
   logic [7:0] dp_inbus_b, dp_outbus_b, quotient_b, remainder_b;

   logic       start_ready_m, res_valid_m, div_by_zero_m, busy_m;
   logic [2:0] en_m;
   logic [7:0] inbus_m, quotient_m, remainder_m;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   logic [2:0] en_log    [0:4095];
   logic [7:0] inbus_log [0:4095];

   always #5 clk = ~clk;

   div_sequencer #(.RUN_STEPS(8)) dut_a (
      .clk(clk), .rst(rst),
      .start_valid(start_valid & ~sel), .start_ready(start_ready_a),
      .dividend(dividend), .divisor(divisor),
      .dp_enable(dp_enable_a), .dp_inbus(dp_inbus_a), .dp_outbus(dp_outbus_a),
      .res_valid(res_valid_a), .res_ready(res_ready & ~sel),
      .quotient(quotient_a), .remainder(remainder_a),
      .div_by_zero(div_by_zero_a), .busy(busy_a)
   );

   div_sequencer #(.RUN_STEPS(4)) dut_b (
      .clk(clk), .rst(rst),
      .start_valid(start_valid & sel), .start_ready(start_ready_b),
      .dividend(dividend), .divisor(divisor),
      .dp_enable(dp_enable_b), .dp_inbus(dp_inbus_b), .dp_outbus(dp_outbus_b),
      .res_valid(res_valid_b), .res_ready(res_ready & sel),
      .quotient(quotient_b), .remainder(remainder_b),
      .div_by_zero(div_by_zero_b), .busy(busy_b)
   );

   assign start_ready_m = sel ? start_ready_b : start_ready_a;
   assign res_valid_m   = sel ? res_valid_b   : res_valid_a;
   assign div_by_zero_m = sel ? div_by_zero_b : div_by_zero_a;
   assign busy_m        = sel ? busy_b        : busy_a;
   assign en_m          = sel ? dp_enable_b   : dp_enable_a;
   assign inbus_m       = sel ? dp_inbus_b    : dp_inbus_a;
   assign quotient_m    = sel ? quotient_b    : quotient_a;
   assign remainder_m   = sel ? remainder_b   : remainder_a;

   // Restoring division step on w-bit operands: shift {A,Q}, trial-subtract M
   function automatic logic [31:0] dp_step(input int unsigned a, input int unsigned q,
                                           input int unsigned m, input int unsigned w);
      int unsigned mask;
      mask = (32'd1 << w) - 1;
      a = (a << 1) | ((q >> (w - 1)) & 1);
      q = (q << 1) & mask;
      if (a >= m) begin
         a = a - m;
         q = q | 1;
      end
      return {a[15:0], q[15:0]};
   endfunction

   // Behavioural datapath models responding to command levels
   int unsigned a8 = 0, q8 = 0, m8 = 0, a4 = 0, q4 = 0, m4 = 0;
   logic [31:0] st8, st4;

   always @(posedge clk) begin
      case (dp_enable_a)
         3'd1: begin a8 = 0; q8 = 0; m8 = 0; end
         3'd2: q8 = {24'd0, dp_inbus_a};
         3'd3: m8 = {24'd0, dp_inbus_a};
         3'd4: begin st8 = dp_step(a8, q8, m8, 8); a8 = {16'd0, st8[31:16]}; q8 = {16'd0, st8[15:0]}; end
         default: ;
      endcase
      case (dp_enable_b)
         3'd1: begin a4 = 0; q4 = 0; m4 = 0; end
         3'd2: q4 = {28'd0, dp_inbus_b[3:0]};
         3'd3: m4 = {28'd0, dp_inbus_b[3:0]};
         3'd4: begin st4 = dp_step(a4, q4, m4, 4); a4 = {16'd0, st4[31:16]}; q4 = {16'd0, st4[15:0]}; end
         default: ;
      endcase
   end

   assign dp_outbus_a = (dp_enable_a == 3'd5) ? a8[7:0] : (dp_enable_a == 3'd6) ? q8[7:0] : 8'd0;
   assign dp_outbus_b = (dp_enable_b == 3'd5) ? {4'd0, a4[3:0]} :
                        (dp_enable_b == 3'd6) ? {4'd0, q4[3:0]} : 8'd0;

   always @(posedge clk) cyc++;

   // Command/inbus log indexed by edge number
   always @(negedge clk) begin
      if (cyc < 4096) begin
         en_log[cyc]    = en_m;
         inbus_log[cyc] = inbus_m;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic run_div(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                          input logic [7:0] exp_q, input logic [7:0] exp_r, input logic exp_dz,
                          input int rs, input int hold, input bit chk_trace);
      int t, acc, lat, exp_lat, nz, exp_cmd, idx;
      logic [7:0] exp_in;
      exp_lat = exp_dz ? 1 : 13 + 2 * rs;
      t = 0;
      while (start_ready_m !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      check({tag, "_start_ready"}, start_ready_m, 1);
      dividend = dvd; divisor = dvs; start_valid = 1'b1;
      @(negedge clk);
      acc = cyc;
      start_valid = 1'b0;
      check({tag, "_busy"}, busy_m, 1);
      t = 0;
      while (res_valid_m !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      lat = cyc - acc;
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_quotient"}, quotient_m, exp_q);
      check({tag, "_remainder"}, remainder_m, exp_r);
      check({tag, "_div_by_zero"}, div_by_zero_m, exp_dz);
      nz = 0;
      for (int k = 0; k <= lat && acc + k < 4096; k++) if (en_log[acc + k] != 3'd0) nz++;
      check({tag, "_cmd_count"}, nz, exp_dz ? 0 : 6 + rs);
      if (chk_trace) begin
         for (int k = 1; k <= exp_lat; k++) begin
            idx = (k - 1) / 2;
            if (k % 2 == 0 || k == exp_lat) exp_cmd = 0;
            else if (idx == 0) exp_cmd = 1;
            else if (idx == 1) exp_cmd = 2;
            else if (idx == 2) exp_cmd = 3;
            else if (idx == 3) exp_cmd = 7;
            else if (idx < 4 + rs) exp_cmd = 4;
            else if (idx == 4 + rs) exp_cmd = 5;
            else exp_cmd = 6;
            exp_in = (k == 3 || k == 4) ? dvd : (k == 5 || k == 6) ? dvs : 8'd0;
            check($sformatf("%s_cmd@%0d", tag, k), en_log[acc + k], exp_cmd);
            check($sformatf("%s_inbus@%0d", tag, k), inbus_log[acc + k], exp_in);
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, res_valid_m, 1);
         check({tag, "_hold_q"}, quotient_m, exp_q);
         check({tag, "_hold_r"}, remainder_m, exp_r);
         check({tag, "_hold_start_ready"}, start_ready_m, 0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, res_valid_m, 0);
      check({tag, "_ready_after_hs"}, start_ready_m, 0);
      @(negedge clk);
      check({tag, "_ready_next"}, start_ready_m, 1);
   endtask

   initial begin
      int acc, t;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      check("rst_start_ready", start_ready_a, 0);
      check("rst_dp_enable", dp_enable_a, 0);
      check("rst_dp_inbus", dp_inbus_a, 0);
      check("rst_res_valid", res_valid_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_quotient", quotient_a, 0);
      check("rst_remainder", remainder_a, 0);
      check("rst_dbz", div_by_zero_a, 0);
      rst = 1'b0;

      run_div("nominal", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, 0, 1'b1);
      run_div("dbz", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 8, 0, 1'b0);
      run_div("bp", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, 5, 1'b0);

      // Reset in the middle of the RUN loop
      t = 0;
      while (start_ready_a !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      dividend = 8'd100; divisor = 8'd7; start_valid = 1'b1;
      @(negedge clk);
      acc = cyc;
      start_valid = 1'b0;
      while (cyc < acc + 14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_dp_enable", dp_enable_a, 0);
      check("midrst_res_valid", res_valid_a, 0);
      check("midrst_busy", busy_a, 0);
      check("midrst_start_ready", start_ready_a, 0);
      check("midrst_quotient", quotient_a, 0);
      rst = 1'b0;
      run_div("after_rst", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8, 0, 1'b1);

      sel = 1'b1;
      run_div("b2b_1", 8'd13, 8'd5, 8'd2, 8'd3, 1'b0, 4, 0, 1'b1);
      run_div("b2b_2", 8'd15, 8'd4, 8'd3, 8'd3, 1'b0, 4, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
